// File: rtl/bpu_update_sched.sv
// bpu_update_sched: branch resolution collector between the two execute
// pipes and the BPU. It issues one registered redirect for the oldest
// mispredict and masks wrong-path results until the backend reports that the
// flush is complete. All accepted resolution records are queued in a small
// FIFO, which drains to the BPU update port.

package bpu_pkg;
   typedef struct packed {
      logic        miss;
      logic        true_taken;
      logic [31:0] pc;
      logic [31:0] true_target;
   } bpu_correct_t;
endpackage

// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | accepting results; a mispredict triggers a redirect
// FLUSH | redirect issued; all valid_i are ignored until flush_done_i
module bpu_update_sched #(
   parameter int QDEPTH = 4,
   parameter int PIPES  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [PIPES-1:0]      valid_i,
   input  bpu_pkg::bpu_correct_t correct_i [PIPES],
   output logic                  stall_o,
   output logic                  redirect_o,
   output logic [31:0]           redirect_pc_o,
   input  logic                  flush_done_i,
   output logic                  update_valid_o,
   output bpu_pkg::bpu_correct_t update_o,
   input  logic                  update_ready_i,
   output logic                  busy_o
);
   import bpu_pkg::*;

   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = PW + 1;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic           redirect_q, redirect_d;
   logic [31:0]    redirect_pc_q, redirect_pc_d;

   bpu_correct_t   mem_q [QDEPTH];
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;

   logic           acc0, acc1;
   logic           miss0_take, miss1_take;
   logic           push0, push1, pop;
   logic [CW-1:0]  free_slots;
   logic [PW-1:0]  wr_ptr_p1;
   logic [PW-1:0]  wr_slot1;
   bpu_correct_t   sel_rec;

   // Acceptance and wrong-path masking: only IDLE accepts results, and a
   // younger pipe-1 result behind a pipe-0 miss is dropped.
   always_comb begin
      acc0 = 1'b0;
      acc1 = 1'b0;
      if (state_q == IDLE) begin
         acc0 = valid_i[0];
         acc1 = valid_i[1] & ~(valid_i[0] & correct_i[0].miss);
      end
      miss0_take = acc0 & correct_i[0].miss;
      miss1_take = acc1 & correct_i[1].miss;
   end

   // FIFO push/pop decisions. Free space comes from the registered count
   // only, so a push into a full FIFO is dropped even when a pop happens in
   // the same cycle.
   always_comb begin
      free_slots = CW'(QDEPTH) - count_q;
      pop        = (count_q != '0) & update_ready_i;
      push0      = acc0 & (free_slots >= CW'(1));
      push1      = acc1 & (free_slots >= (push0 ? CW'(2) : CW'(1)));
      wr_ptr_p1  = wr_ptr_q + PW'(1);
      wr_slot1   = push0 ? wr_ptr_p1 : wr_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      if (push0 & push1) wr_ptr_d = wr_ptr_q + PW'(2);
      else if (push0 | push1) wr_ptr_d = wr_ptr_p1;
      rd_ptr_d   = pop ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
      count_d    = count_q + CW'(push0) + CW'(push1) - CW'(pop);
   end

   // Redirect FSM next state: the oldest accepted miss wins and is turned
   // into a one-cycle registered redirect pulse.
   always_comb begin
      state_d       = state_q;
      redirect_d    = 1'b0;
      redirect_pc_d = redirect_pc_q;
      sel_rec       = miss0_take ? correct_i[0] : correct_i[1];
      case (state_q)
         IDLE: begin
            if (miss0_take | miss1_take) begin
               state_d       = FLUSH;
               redirect_d    = 1'b1;
               redirect_pc_d = sel_rec.true_taken ? sel_rec.true_target
                                                  : (sel_rec.pc + 32'd4);
            end
         end
         FLUSH: begin
            if (flush_done_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control registers: FSM state, redirect outputs, FIFO pointers and count.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         state_q       <= state_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
      end
   end

   // FIFO storage: pipe 0 is written first so program order is preserved.
   always_ff @(posedge clk) begin
      if (push0) mem_q[wr_ptr_q] <= correct_i[0];
      if (push1) mem_q[wr_slot1] <= correct_i[1];
   end

   // Outputs come from registered state only.
   always_comb begin
      stall_o        = (CW'(QDEPTH) - count_q) < CW'(2);
      update_valid_o = (count_q != '0);
      update_o       = mem_q[rd_ptr_q];
      redirect_o     = redirect_q;
      redirect_pc_o  = redirect_pc_q;
      busy_o         = (state_q == FLUSH) | (count_q != '0);
   end

endmodule

// File: tb/tb_bpu_update_sched.sv
// Directed testbench for bpu_update_sched with hand-computed expectations.
module tb_bpu_update_sched;
   import bpu_pkg::*;

   logic                 clk;
   logic                 rst;
   logic [1:0]           valid_i;
   bpu_correct_t         correct_i [2];
   logic                 stall_o;
   logic                 redirect_o;
   logic [31:0]          redirect_pc_o;
   logic                 flush_done_i;
   logic                 update_valid_o;
   bpu_correct_t         update_o;
   logic                 update_ready_i;
   logic                 busy_o;

   int vectors;
   int miscompares;

   bpu_update_sched #(.QDEPTH(4), .PIPES(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .valid_i        (valid_i),
      .correct_i      (correct_i),
      .stall_o        (stall_o),
      .redirect_o     (redirect_o),
      .redirect_pc_o  (redirect_pc_o),
      .flush_done_i   (flush_done_i),
      .update_valid_o (update_valid_o),
      .update_o       (update_o),
      .update_ready_i (update_ready_i),
      .busy_o         (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bpu_correct_t mk(input logic miss, input logic taken,
                                       input logic [31:0] pc,
                                       input logic [31:0] tgt);
      bpu_correct_t r;
      r.miss        = miss;
      r.true_taken  = taken;
      r.pc          = pc;
      r.true_target = tgt;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [65:0] obs,
                      input logic [65:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectors        = 0;
      miscompares    = 0;
      rst            = 1'b1;
      valid_i        = 2'b00;
      correct_i[0]   = '0;
      correct_i[1]   = '0;
      flush_done_i   = 1'b0;
      update_ready_i = 1'b0;
      tick();
      tick();
      chk("rst_redirect",  66'(redirect_o), 66'(0));
      chk("rst_pc",        66'(redirect_pc_o), 66'(0));
      chk("rst_uvalid",    66'(update_valid_o), 66'(0));
      chk("rst_stall",     66'(stall_o), 66'(0));
      chk("rst_busy",      66'(busy_o), 66'(0));
      rst = 1'b0;

      // 1: single hit on pipe 0
      valid_i      = 2'b01;
      correct_i[0] = mk(1'b0, 1'b0, 32'h1C000100, 32'h0);
      tick();
      valid_i = 2'b00;
      chk("t1_redirect", 66'(redirect_o), 66'(0));
      chk("t1_uvalid",   66'(update_valid_o), 66'(1));
      chk("t1_head",     66'(update_o), 66'(mk(1'b0, 1'b0, 32'h1C000100, 32'h0)));
      chk("t1_busy",     66'(busy_o), 66'(1));
      update_ready_i = 1'b1;
      tick();
      update_ready_i = 1'b0;
      chk("t1_empty",    66'(update_valid_o), 66'(0));
      chk("t1_idle",     66'(busy_o), 66'(0));

      // 2: both pipes miss, pipe 0 wins
      valid_i      = 2'b11;
      correct_i[0] = mk(1'b1, 1'b0, 32'h1C000200, 32'h1C000AAA);
      correct_i[1] = mk(1'b1, 1'b1, 32'h1C000204, 32'h1C000900);
      tick();
      valid_i = 2'b00;
      chk("t2_redirect", 66'(redirect_o), 66'(1));
      chk("t2_pc",       66'(redirect_pc_o), 66'(32'h1C000204));
      chk("t2_head",     66'(update_o), 66'(mk(1'b1, 1'b0, 32'h1C000200, 32'h1C000AAA)));
      chk("t2_stall",    66'(stall_o), 66'(0));
      update_ready_i = 1'b1;
      tick();
      update_ready_i = 1'b0;
      chk("t2_pulse_end", 66'(redirect_o), 66'(0));
      chk("t2_pc_hold",   66'(redirect_pc_o), 66'(32'h1C000204));
      chk("t2_one_entry", 66'(update_valid_o), 66'(0));
      chk("t2_busy_flush", 66'(busy_o), 66'(1));
      flush_done_i = 1'b1;
      tick();
      flush_done_i = 1'b0;
      chk("t2_back_idle", 66'(busy_o), 66'(0));

      // 3: younger miss on pipe 1
      valid_i      = 2'b11;
      correct_i[0] = mk(1'b0, 1'b0, 32'h00000100, 32'h0);
      correct_i[1] = mk(1'b1, 1'b1, 32'h00000300, 32'h00002000);
      tick();
      valid_i = 2'b00;
      chk("t3_redirect", 66'(redirect_o), 66'(1));
      chk("t3_pc",       66'(redirect_pc_o), 66'(32'h00002000));
      chk("t3_head0",    66'(update_o), 66'(mk(1'b0, 1'b0, 32'h100, 32'h0)));
      update_ready_i = 1'b1;
      tick();
      chk("t3_head1",    66'(update_o), 66'(mk(1'b1, 1'b1, 32'h300, 32'h2000)));
      chk("t3_uvalid1",  66'(update_valid_o), 66'(1));
      tick();
      update_ready_i = 1'b0;
      chk("t3_drained",  66'(update_valid_o), 66'(0));

      // 4: FLUSH masking (still in FLUSH from test 3)
      valid_i      = 2'b11;
      correct_i[0] = mk(1'b1, 1'b0, 32'h00000500, 32'h0);
      correct_i[1] = mk(1'b1, 1'b1, 32'h00000504, 32'h00007000);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t4_no_redirect", 66'(redirect_o), 66'(0));
         chk("t4_no_push",     66'(update_valid_o), 66'(0));
         chk("t4_pc_hold",     66'(redirect_pc_o), 66'(32'h00002000));
      end
      valid_i      = 2'b00;
      flush_done_i = 1'b1;
      tick();
      flush_done_i = 1'b0;
      chk("t4_idle", 66'(busy_o), 66'(0));
      valid_i      = 2'b01;
      correct_i[0] = mk(1'b1, 1'b0, 32'hFFFFFFFC, 32'h12345678);
      tick();
      valid_i = 2'b00;
      chk("t4_wrap_redirect", 66'(redirect_o), 66'(1));
      chk("t4_wrap_pc",       66'(redirect_pc_o), 66'(32'h00000000));
      update_ready_i = 1'b1;
      flush_done_i   = 1'b1;
      tick();
      update_ready_i = 1'b0;
      flush_done_i   = 1'b0;
      chk("t4_done_busy", 66'(busy_o), 66'(0));

      // 5: backpressure
      valid_i      = 2'b11;
      correct_i[0] = mk(1'b0, 1'b0, 32'hA0, 32'h0);
      correct_i[1] = mk(1'b0, 1'b0, 32'hA1, 32'h0);
      tick();
      chk("t5_stall_c2", 66'(stall_o), 66'(0));
      valid_i      = 2'b01;
      correct_i[0] = mk(1'b0, 1'b0, 32'hA2, 32'h0);
      tick();
      chk("t5_stall_c3", 66'(stall_o), 66'(1));
      valid_i      = 2'b11;
      correct_i[0] = mk(1'b0, 1'b0, 32'hA3, 32'h0);
      correct_i[1] = mk(1'b0, 1'b0, 32'hA4, 32'h0);
      tick();
      chk("t5_stall_c4", 66'(stall_o), 66'(1));
      correct_i[0] = mk(1'b0, 1'b0, 32'hA5, 32'h0);
      correct_i[1] = mk(1'b0, 1'b0, 32'hA6, 32'h0);
      tick();
      valid_i = 2'b00;
      chk("t5_full_head", 66'(update_o), 66'(mk(1'b0, 1'b0, 32'hA0, 32'h0)));
      chk("t5_full_stall", 66'(stall_o), 66'(1));
      update_ready_i = 1'b1;
      tick();
      chk("t5_drain_a1", 66'(update_o.pc), 66'(32'hA1));
      chk("t5_stall_c3b", 66'(stall_o), 66'(1));
      tick();
      chk("t5_drain_a2", 66'(update_o.pc), 66'(32'hA2));
      chk("t5_stall_c2b", 66'(stall_o), 66'(0));
      tick();
      chk("t5_drain_a3", 66'(update_o.pc), 66'(32'hA3));
      chk("t5_last_valid", 66'(update_valid_o), 66'(1));
      tick();
      update_ready_i = 1'b0;
      chk("t5_empty", 66'(update_valid_o), 66'(0));
      chk("t5_idle",  66'(busy_o), 66'(0));

      // 6: reset mid-FLUSH with three entries queued
      valid_i      = 2'b11;
      correct_i[0] = mk(1'b0, 1'b0, 32'hB0, 32'h0);
      correct_i[1] = mk(1'b0, 1'b0, 32'hB1, 32'h0);
      tick();
      valid_i      = 2'b01;
      correct_i[0] = mk(1'b1, 1'b1, 32'hB2, 32'h0000B000);
      tick();
      valid_i = 2'b00;
      chk("t6_pre_redirect", 66'(redirect_o), 66'(1));
      chk("t6_pre_stall",    66'(stall_o), 66'(1));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_uvalid",   66'(update_valid_o), 66'(0));
      chk("t6_busy",     66'(busy_o), 66'(0));
      chk("t6_redirect", 66'(redirect_o), 66'(0));
      chk("t6_stall",    66'(stall_o), 66'(0));
      chk("t6_pc",       66'(redirect_pc_o), 66'(0));
      valid_i      = 2'b01;
      correct_i[0] = mk(1'b0, 1'b0, 32'hC0, 32'h0);
      tick();
      valid_i = 2'b00;
      chk("t6_accept",   66'(update_o), 66'(mk(1'b0, 1'b0, 32'hC0, 32'h0)));
      chk("t6_uvalid2",  66'(update_valid_o), 66'(1));
      chk("t6_no_redir", 66'(redirect_o), 66'(0));
      update_ready_i = 1'b1;
      tick();
      update_ready_i = 1'b0;
      chk("t6_final_empty", 66'(update_valid_o), 66'(0));
      chk("t6_final_busy",  66'(busy_o), 66'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bpu_update_sched.md
Name: bpu_update_sched

Overview:
- Sits between the two execute-stage branch-resolution units and the BPU.
- Collects per-pipe bpu_correct_t records and picks the oldest mispredict. Issues a single registered frontend redirect, then masks wrong-path results until the backend reports the flush is complete.
- Queues all resolved-branch training records in a small FIFO. The FIFO drains to the BPU's single update port through a valid/ready handshake.

Parameters:
- QDEPTH, 4, training FIFO entries; power of two, minimum 2.
- PIPES, 2, resolution pipes; fixed at 2. Pipe 0 is always older than pipe 1 in the same cycle.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous, active-high reset.
- valid_i  input  2  bit p: pipe p resolves a branch this cycle.
- correct_i  input  2 x bpu_correct_t  per-pipe correction record. Fields used: miss, pc, true_taken, true_target.
- stall_o  output  1  hold execute; FIFO cannot accept two pushes.
- redirect_o  output  1  one-cycle frontend redirect pulse.
- redirect_pc_o  output  32  redirect target.
- flush_done_i  input  1  backend finished squashing younger instructions.
- update_valid_o  output  1  FIFO head valid toward BPU.
- update_o  output  bpu_correct_t  FIFO head record.
- update_ready_i  input  1  BPU accepts head this cycle.
- busy_o  output  1  state is FLUSH or FIFO is non-empty.

Behaviour:

Reset (rst=1 at clk edge):
- state=IDLE; FIFO pointers and count = 0.
- redirect_o=0, redirect_pc_o=0.
- update_valid_o=0, stall_o=0, busy_o=0.
- A reset asserted mid-FLUSH or with a non-empty FIFO discards everything. No update is emitted after reset.

Acceptance and mask (IDLE only):
- acc0 = valid_i[0].
- acc1 = valid_i[1] & !(valid_i[0] & correct_i[0].miss). A younger result behind an older miss is wrong-path and is dropped.
- In FLUSH, acc0 = acc1 = 0. All valid_i are ignored, including misses.

FIFO:
- Pushes: acc0 first, then acc1, preserving program order. Up to 2 pushes and 1 pop per cycle.
- Pop when update_valid_o & update_ready_i.
- count' = count + acc0 + acc1 - pop. Pointers wrap modulo QDEPTH.
- update_valid_o = (count != 0). update_o = entry at read pointer. Both come from registers and are never combinational from valid_i.
- A record pushed in cycle N is visible at update_o no earlier than cycle N+1.
- stall_o = (QDEPTH - count) < 2, using registered count and combinational decode.
  - Upstream guarantees valid_i = 0 while stall_o = 1.
  - If that is violated, pushes beyond free space are dropped, count saturates at QDEPTH, and no existing entry is corrupted.
- Simultaneous pop and push at full (count == QDEPTH, one push) is legal only if stall_o is low, which cannot happen. In that case the push is dropped per the rule above.

Redirect FSM (states IDLE, FLUSH):
- IDLE to FLUSH: set sel = 0 if (acc0 & miss0), else sel = 1 if (acc1 & miss1); transition when either condition holds.
  - On the next cycle, redirect_o = 1 for exactly one cycle.
  - redirect_pc_o = correct_i[sel].true_taken ? true_target : pc + 32'd4. The +4 wraps modulo 2^32.
  - redirect_pc_o holds its value until the next redirect.
- FLUSH to IDLE: on flush_done_i=1. Valid results are accepted again starting the following cycle.
- flush_done_i in IDLE: ignored.
- flush_done_i in the same cycle as the redirect_o pulse: legal; returns to IDLE.
- The FIFO keeps draining in both states. The mispredicting record itself is always enqueued.
- busy_o = (state == FLUSH) | (count != 0).

Test Plan:
1. Single hit: valid_i=01, pipe0 {miss=0, pc=0x1C000100}. Expect no redirect, update_valid_o=1 next cycle with pc 0x1C000100. With ready=1 the FIFO empties and busy_o=0.
2. Both pipes miss: valid_i=11. Pipe0 {miss=1, taken=0, pc=0x1C000200}, pipe1 {miss=1, taken=1, target=0x1C000900}. Expect redirect_o pulse with redirect_pc_o=0x1C000204. Exactly one update (pipe0) is queued.
3. Younger miss: pipe0 hit {pc=0x100}, pipe1 miss {taken=1, target=0x2000}. Expect redirect_pc_o=0x2000. The FIFO outputs 0x100 then pipe1's record, in that order.
4. FLUSH masking: after a miss, drive valid_i=11 with misses for 3 cycles before flush_done_i. Expect no further redirect and count unchanged. After flush_done_i, a new miss at pc=0xFFFFFFFC with taken=0 gives redirect_pc_o=0x00000000.
5. Backpressure, QDEPTH=4, update_ready_i=0:
   - Push 2 per cycle; stall_o=1 once count reaches 3.
   - Forcing valid_i=11 at count=4 keeps count=4, with the head entry unchanged.
   - Raising ready drains one entry per cycle, in order.
6. Reset mid-FLUSH with count=3: assert rst for 1 cycle. Expect state IDLE, update_valid_o=0, busy_o=0, redirect_o=0. The next valid_i is accepted normally.
